// File: rtl/sobel_row_feeder.sv
// rtl/sobel_row_feeder.sv - serial pixels to double-buffered parallel rows for the Sobel array
// Define SOBEL_FEED_PAD_EN to append an all-zero pad row after each frame's final row.
module sobel_row_feeder #(
  parameter int SIZE = 100,
  parameter int ROWS = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     sof,
  output logic [7:0]               arr_out [SIZE],
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     last_row,
  output logic                     sof_err
);

  localparam int CW = $clog2(SIZE);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [7:0]    fill_q [SIZE];
  logic [7:0]    fill_d [SIZE];
  logic [7:0]    arr_q  [SIZE];
  logic [7:0]    arr_d  [SIZE];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic [RW-1:0] fill_tag_q, fill_tag_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          fill_full_q, fill_full_d;
  logic          row_valid_q, row_valid_d;
  logic          last_row_q, last_row_d;
  logic          sof_err_q, sof_err_d;
`ifdef SOBEL_FEED_PAD_EN
  logic          fill_pad_q, fill_pad_d;
`endif

  logic out_free, xfer, block, ready_c, accept, row_done, bypass;

  always_comb begin
    out_free = !row_valid_q || row_ready;
    xfer     = fill_full_q && out_free;
`ifdef SOBEL_FEED_PAD_EN
    // Intake pauses while the final row or its pad still waits in the fill buffer.
    block    = fill_full_q && (fill_pad_q || fill_tag_q == ROW_LAST);
`else
    block    = 1'b0;
`endif
    ready_c  = !block && (!fill_full_q || xfer);
    accept   = pix_valid && ready_c;
    row_done = accept && !sof && (col_q == COL_LAST);
    // A row completing into an empty fill buffer goes straight to the output register.
    bypass   = row_done && out_free && !fill_full_q;
  end

  always_comb begin
    fill_d      = fill_q;
    arr_d       = arr_q;
    col_d       = col_q;
    wrow_d      = wrow_q;
    fill_tag_d  = fill_tag_q;
    fill_full_d = fill_full_q;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
    last_row_d  = last_row_q;
    sof_err_d   = 1'b0;
`ifdef SOBEL_FEED_PAD_EN
    fill_pad_d  = fill_pad_q;
`endif

    if (accept) begin
      if (sof) begin
        fill_d[0] = pix_in;
        col_d     = CW'(1);
        wrow_d    = '0;
        sof_err_d = (col_q != '0);
      end else begin
        fill_d[col_q] = pix_in;
        if (row_done) begin
          col_d  = '0;
          wrow_d = (wrow_q == ROW_LAST) ? '0 : wrow_q + RW'(1);
        end else begin
          col_d  = col_q + CW'(1);
        end
      end
    end

    if (xfer) begin
      row_valid_d = 1'b1;
`ifdef SOBEL_FEED_PAD_EN
      if (fill_pad_q) begin
        for (int c = 0; c < SIZE; c++) arr_d[c] = 8'd0;
        row_idx_d   = ROW_LAST;
        last_row_d  = 1'b1;
        fill_full_d = 1'b0;
        fill_pad_d  = 1'b0;
      end else begin
        arr_d       = fill_q;
        row_idx_d   = fill_tag_q;
        last_row_d  = 1'b0;
        fill_full_d = (fill_tag_q == ROW_LAST);
        fill_pad_d  = (fill_tag_q == ROW_LAST);
      end
`else
      arr_d       = fill_q;
      row_idx_d   = fill_tag_q;
      last_row_d  = (fill_tag_q == ROW_LAST);
      fill_full_d = 1'b0;
`endif
    end else if (bypass) begin
      for (int c = 0; c < SIZE; c++) arr_d[c] = fill_q[c];
      arr_d[SIZE-1] = pix_in;
      row_valid_d   = 1'b1;
      row_idx_d     = wrow_q;
`ifdef SOBEL_FEED_PAD_EN
      last_row_d    = 1'b0;
      if (wrow_q == ROW_LAST) begin
        fill_full_d = 1'b1;
        fill_pad_d  = 1'b1;
      end
`else
      last_row_d    = (wrow_q == ROW_LAST);
`endif
    end else if (row_valid_q && row_ready) begin
      row_valid_d = 1'b0;
    end

    if (row_done && !bypass) begin
      fill_full_d = 1'b1;
      fill_tag_d  = wrow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < SIZE; c++) begin
        fill_q[c] <= 8'd0;
        arr_q[c]  <= 8'd0;
      end
      col_q       <= '0;
      wrow_q      <= '0;
      fill_tag_q  <= '0;
      fill_full_q <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      last_row_q  <= 1'b0;
      sof_err_q   <= 1'b0;
`ifdef SOBEL_FEED_PAD_EN
      fill_pad_q  <= 1'b0;
`endif
    end else begin
      fill_q      <= fill_d;
      arr_q       <= arr_d;
      col_q       <= col_d;
      wrow_q      <= wrow_d;
      fill_tag_q  <= fill_tag_d;
      fill_full_q <= fill_full_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      last_row_q  <= last_row_d;
      sof_err_q   <= sof_err_d;
`ifdef SOBEL_FEED_PAD_EN
      fill_pad_q  <= fill_pad_d;
`endif
    end
  end

  assign pix_ready = ready_c;
  assign arr_out   = arr_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign last_row  = last_row_q;
  assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_sobel_row_feeder.sv
// tb/tb_sobel_row_feeder.sv - self-checking bench for sobel_row_feeder against a row-queue model
module tb_sobel_row_feeder;
  localparam int SIZE = 4;
  localparam int ROWS = 3;
  localparam int RW   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          sof;
  logic [7:0]    arr_out [SIZE];
  logic          row_valid;
  logic          row_ready;
  logic [RW-1:0] row_idx;
  logic          last_row;
  logic          sof_err;

  always #5 clk = ~clk;

  sobel_row_feeder #(.SIZE(SIZE), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof(sof), .arr_out(arr_out), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .last_row(last_row), .sof_err(sof_err)
  );

  typedef struct {
    logic [8*SIZE-1:0] data;
    int                idx;
    bit                last;
    bit                pad;
  } row_t;

  // Completed rows not yet taken downstream; head is what arr_out must show.
  row_t         rq[$];
  byte unsigned part[$];
  int           wrow = 0;
  bit           exp_err = 1'b0;
  int           errors = 0;
  int           checks = 0;
  bit           acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*SIZE-1:0] pack_out();
    logic [8*SIZE-1:0] v;
    for (int i = 0; i < SIZE; i++) v[8*i +: 8] = arr_out[i];
    return v;
  endfunction

  function automatic bit model_ready(input bit rr);
    bit blk = 1'b0;
    for (int i = 1; i < rq.size(); i++) if (rq[i].pad) blk = 1'b1;
    return !blk && (rq.size() < 2 || rr);
  endfunction

  task automatic step(input bit r, input bit pv, input byte unsigned px, input bit s,
                      input bit rr, output bit accepted);
    bit   exp_rdy;
    row_t nr;
    row_t pr;
    @(negedge clk);
    rst = r; pix_valid = pv; pix_in = px; sof = s; row_ready = rr;
    #1;
    exp_rdy = model_ready(rr);
    chk("pix_ready", pix_ready, exp_rdy);
    chk("row_valid", row_valid, rq.size() > 0);
    chk("sof_err", sof_err, exp_err);
    if (rq.size() > 0) begin
      chk("arr_out", pack_out(), rq[0].data);
      chk("row_idx", row_idx, rq[0].idx);
      chk("last_row", last_row, rq[0].last);
    end
    @(posedge clk);
    accepted = !r && pv && exp_rdy;
    if (r) begin
      rq.delete(); part.delete(); wrow = 0; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (rq.size() > 0 && rr) void'(rq.pop_front());
      if (accepted) begin
        if (s) begin
          exp_err = (part.size() != 0);
          part.delete();
          part.push_back(px);
          wrow = 0;
        end else begin
          part.push_back(px);
          if (part.size() == SIZE) begin
            nr.data = '0;
            for (int i = 0; i < SIZE; i++) nr.data[8*i +: 8] = part[i];
            nr.idx = wrow;
            nr.pad = 1'b0;
`ifdef SOBEL_FEED_PAD_EN
            nr.last = 1'b0;
            rq.push_back(nr);
            if (wrow == ROWS - 1) begin
              pr.data = '0; pr.idx = ROWS - 1; pr.last = 1'b1; pr.pad = 1'b1;
              rq.push_back(pr);
            end
`else
            nr.last = (wrow == ROWS - 1);
            rq.push_back(nr);
`endif
            wrow = (wrow + 1) % ROWS;
            part.delete();
          end
        end
      end
    end
  endtask

  task automatic send(input byte unsigned px, input bit s, input bit rr);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 20) begin
      step(1'b0, 1'b1, px, s, rr, a);
      n++;
    end
    if (!a) chk("send_timeout", a, 1);
  endtask

  task automatic idle(input int n, input bit rr);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0, rr, a);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = 8'd0; sof = 1'b0; row_ready = 1'b0;
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'd55, 1'b1, 1'b1, acc);
    #2;
    chk("rst_arr_out", pack_out(), '0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_last_row", last_row, 0);

    for (int p = 1; p <= 4; p++) send(byte'(p), 1'b0, 1'b1);
    #2;
    chk("first_row_valid", row_valid, 1);
    chk("first_row_data", pack_out(), 32'h04030201);
    chk("first_row_idx", row_idx, 0);

    for (int p = 10; p <= 13; p++) send(byte'(p), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'd14, 1'b0, 1'b0, acc);
    for (int p = 14; p <= 17; p++) send(byte'(p), 1'b0, 1'b1);
    idle(3, 1'b1);

    for (int p = 0; p < 12; p++) send(byte'(40 + p), p == 0, 1'b1);
    idle(3, 1'b1);

    send(8'd5, 1'b0, 1'b1);
    send(8'd6, 1'b0, 1'b1);
    send(8'd9, 1'b1, 1'b1);
    send(8'd7, 1'b0, 1'b1);
    send(8'd8, 1'b0, 1'b1);
    send(8'd6, 1'b0, 1'b1);
    #2;
    chk("sof_row_data", pack_out(), 32'h06080709);
    chk("sof_row_idx", row_idx, 0);
    idle(2, 1'b1);

    send(8'd30, 1'b0, 1'b0);
    send(8'd31, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd32, 1'b0, 1'b0, acc);
    for (int p = 20; p <= 23; p++) send(byte'(p), 1'b0, 1'b1);
    #2;
    chk("post_rst_row", pack_out(), 32'h17161514);
    idle(2, 1'b1);

    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, acc);
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
